peb_frame_sched: RTL and testbench
==================================

# peb_frame_sched

Frame and block sequencer for one PEB. It issues block starts to the 3-PEC chain and generates the first-block flag (`frt_blk`) and the frame-finish pulse (`fnh_frm`) that steer the PEB partial-sum SRAM muxing and the ping-pong flag. After each frame it drains the finished partial-sum bank to the pooling unit through the PEB pool read port. It sits between the top-level layer controller, the PEB, and POOL.

## Interface
**Parameters**
- `LENPSUM`, default 16: partial-sum SRAM depth, i.e. words drained per frame.
- `ADDR_W`, default `$clog2(LENPSUM)`: width of the pool read address.
- `CNT_W`, default 8: width of the block and frame counters.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: one-cycle pulse that starts a layer. Ignored while `busy`.
- `cfg_num_blk` in `CNT_W`: blocks per frame. Sampled on an accepted `cfg_start`. A value of 0 is treated as 1.
- `cfg_num_frm` in `CNT_W`: frames per layer. Sampled on an accepted `cfg_start`. A value of 0 is treated as 1.
- `blk_start` out 1: one-cycle pulse that launches one activation block into the PEC chain.
- `blk_done` in 1: one-cycle pulse meaning the PEC chain finished the launched block (last PEC `LstActBlk`).
- `frt_blk` out 1: level signal, high while block 0 of the current frame is outstanding. Drives `CTRLPEB_FrtBlk`.
- `fnh_frm` out 1: one-cycle pulse at frame end. Drives `CTRLPEB_FnhFrm`.
- `pool_rdy` in 1: POOL can accept one word this cycle.
- `pool_en_rd` out 1: read enable for the drained bank. Drives `POOLPEB_EnRd`.
- `pool_addr_rd` out `ADDR_W`: read address. Drives `POOLPEB_AddrRd`.
- `pool_vld` out 1: `PEBPOOL_Dat` is valid this cycle.
- `pool_last` out 1: qualifies `pool_vld` for address `LENPSUM-1`.
- `busy` out 1: high from an accepted `cfg_start` until `done`.
- `done` out 1: one-cycle pulse when the layer is complete and drained.

## Operation
**Main FSM**
- States: IDLE, LAUNCH, WAITBLK, ENDFRM, FLUSH.
- IDLE → LAUNCH on `cfg_start`. Latch both counts; clear `blk_cnt` and `frm_cnt`; set `busy`.
- LAUNCH:
  - Assert `blk_start` for exactly 1 cycle, then go to WAITBLK.
  - If `blk_cnt`==0, set `frt_blk` in the same cycle.
- WAITBLK, on `blk_done`:
  - Clear `frt_blk`.
  - If `blk_cnt`==num_blk-1, go to ENDFRM.
  - Otherwise increment `blk_cnt` and go to LAUNCH.
  - `blk_done` arriving in any other state is ignored.
- ENDFRM:
  - If the drain engine is idle, pulse `fnh_frm`, clear `blk_cnt`, and signal the drain engine to start.
  - Otherwise hold (stall), with no `blk_start`, until the drain engine is idle.
  - After `fnh_frm`: if `frm_cnt`==num_frm-1, go to FLUSH; else increment `frm_cnt` and go to LAUNCH.
- FLUSH: when the drain engine is idle and has no pending start, pulse `done`, clear `busy`, and go to IDLE.

**Drain engine**
- States: DR_IDLE, DR_READ.
- Starts in the cycle after `fnh_frm`, because the PEB bank flag has toggled by then.
- In DR_READ: `pool_en_rd` = `pool_rdy`.
- `pool_addr_rd` advances 0..LENPSUM-1, incrementing only on cycles where `pool_en_rd` is high.
- After the read at LENPSUM-1 → DR_IDLE. The address resets to 0.

**Data and width rules**
- `pool_vld` and `pool_last` are registered copies of `pool_en_rd` and (`addr`==LENPSUM-1), matching the 1-cycle SRAM read latency.
- Counters compare against count-1 computed in `CNT_W` bits. The zero-to-one substitution is applied on latch.

## Timing
- Reset values: every output is 0. Both FSMs start in their idle states, and all counters are 0.
- `rst_n` asserted mid-layer aborts everything immediately (asynchronous). No `fnh_frm` or `done` is issued.
- `cfg_start` at cycle t → `blk_start` and `frt_blk` rise at t+1.
- `blk_done` at t (not the last block) → `frt_blk` falls at t+1, `blk_start` pulses at t+2.
- `blk_done` at t on the last block, drain idle → `fnh_frm` at t+2. The first `pool_en_rd` can rise at t+3. The next `blk_start` is at t+3.
- Back-to-back: block processing of frame n+1 overlaps the drain of frame n. The stall happens only when frame n+1 ends before drain n completes.
  - If the drain's final read occurs in the same cycle ENDFRM evaluates, that cycle counts as busy and `fnh_frm` comes 1 cycle later.
- Drain throughput: 1 word per cycle with `pool_rdy` held high, so LENPSUM cycles. `pool_rdy` low freezes the address with no reads.
- `done` comes 1 cycle after the last `pool_vld`/`pool_last` of the final frame at the earliest.

## Test plan
- num_blk=3, num_frm=1, LENPSUM=16, `blk_done` 5 cycles after each `blk_start`, `pool_rdy`=1:
  - exactly 3 `blk_start` pulses, `frt_blk` high only for block 0, one `fnh_frm`;
  - 16 `pool_vld` with addresses 0..15, `pool_last` on 15, then `done`.
- num_blk=1, num_frm=3, `pool_rdy` toggling 1/0: `frt_blk` is high for every block; 3 `fnh_frm` pulses; 48 `pool_vld` total; no address is skipped or repeated.
- Drain stall: num_blk=1, `blk_done` 1 cycle after `blk_start`, `pool_rdy`=0 for 40 cycles: the second `fnh_frm` is withheld and no `blk_start` is issued until drain 1 completes.
- cfg_num_blk=0, cfg_num_frm=0: behaves as 1 block and 1 frame. A `cfg_start` issued while `busy` is ignored.
- Spurious `blk_done` in LAUNCH or ENDFRM: ignored, and the block count is unchanged.
- `rst_n` pulsed low during the drain at address 7: all outputs drop to 0 at once; a new `cfg_start` restarts cleanly from address 0.

Source files
------------

// File: rtl/peb_frame_sched.sv
// peb_frame_sched: launches blocks into the PEC chain, flags first block and frame end,
// then drains the finished partial-sum bank to POOL while the next frame proceeds.
module peb_frame_sched #(
    parameter int LENPSUM = 16,
    parameter int ADDR_W  = $clog2(LENPSUM),
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_num_blk,
    input  logic [CNT_W-1:0]  cfg_num_frm,
    output logic              blk_start,
    input  logic              blk_done,
    output logic              frt_blk,
    output logic              fnh_frm,
    input  logic              pool_rdy,
    output logic              pool_en_rd,
    output logic [ADDR_W-1:0] pool_addr_rd,
    output logic              pool_vld,
    output logic              pool_last,
    output logic              busy,
    output logic              done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LAUNCH  = 3'd1;
    localparam logic [2:0] WAITBLK = 3'd2;
    localparam logic [2:0] ENDFRM  = 3'd3;
    localparam logic [2:0] FLUSH   = 3'd4;
    localparam logic       DR_IDLE = 1'b0;
    localparam logic       DR_READ = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENPSUM - 1);

    logic [2:0]        state;
    logic              drState;
    logic [CNT_W-1:0]  numBlk, numFrm, blkCnt, frmCnt;
    logic [ADDR_W-1:0] addr;
    logic              blkAck, frtBlk, poolVld, poolLast;
    logic              drIdle, lastBlk, lastFrm, lastRead, fnhFrm;

    assign drIdle   = drState == DR_IDLE;
    assign lastBlk  = blkCnt == numBlk - CNT_W'(1);
    assign lastFrm  = frmCnt == numFrm - CNT_W'(1);
    assign fnhFrm   = state == ENDFRM && drIdle;
    assign lastRead = pool_en_rd && addr == LAST_ADDR;

    assign blk_start    = state == LAUNCH;
    assign frt_blk      = frtBlk;
    assign fnh_frm      = fnhFrm;
    assign pool_en_rd   = drState == DR_READ && pool_rdy;
    assign pool_addr_rd = addr;
    assign pool_vld     = poolVld;
    assign pool_last    = poolLast;
    assign busy         = state != IDLE;
    assign done         = state == FLUSH && drIdle && !poolVld;

    // blk_done is acknowledged one cycle late so the next launch lands two cycles after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            numBlk <= '0;
            numFrm <= '0;
            blkCnt <= '0;
            frmCnt <= '0;
            blkAck <= 1'b0;
            frtBlk <= 1'b0;
        end else begin
            blkAck <= blk_done && state == WAITBLK && !blkAck;
            case (state)
                IDLE: if (cfg_start) begin
                    numBlk <= cfg_num_blk == '0 ? CNT_W'(1) : cfg_num_blk;
                    numFrm <= cfg_num_frm == '0 ? CNT_W'(1) : cfg_num_frm;
                    blkCnt <= '0;
                    frmCnt <= '0;
                    frtBlk <= 1'b1;
                    state  <= LAUNCH;
                end
                LAUNCH: state <= WAITBLK;
                WAITBLK: begin
                    if (blk_done) frtBlk <= 1'b0;
                    if (blkAck) begin
                        state  <= lastBlk ? ENDFRM : LAUNCH;
                        blkCnt <= lastBlk ? blkCnt : blkCnt + CNT_W'(1);
                    end
                end
                ENDFRM: if (drIdle) begin
                    blkCnt <= '0;
                    frmCnt <= lastFrm ? frmCnt : frmCnt + CNT_W'(1);
                    frtBlk <= !lastFrm;
                    state  <= lastFrm ? FLUSH : LAUNCH;
                end
                FLUSH: if (drIdle && !poolVld) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // the drain starts the cycle after fnh_frm, once the PEB bank flag has toggled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drState  <= DR_IDLE;
            addr     <= '0;
            poolVld  <= 1'b0;
            poolLast <= 1'b0;
        end else begin
            poolVld  <= pool_en_rd;
            poolLast <= lastRead;
            drState  <= fnhFrm ? DR_READ : lastRead ? DR_IDLE : drState;
            if (pool_en_rd) addr <= lastRead ? '0 : addr + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_peb_frame_sched.sv
// tb_peb_frame_sched: directed scenarios for the PEB frame sequencer and bank drain.
module tb_peb_frame_sched;
    localparam int LENPSUM = 16;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 8;

    logic              clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, blk_done = 1'b0, pool_rdy = 1'b0;
    logic [CNT_W-1:0]  cfg_num_blk = '0, cfg_num_frm = '0;
    logic              blk_start, frt_blk, fnh_frm, pool_en_rd, pool_vld, pool_last, busy, done;
    logic [ADDR_W-1:0] pool_addr_rd;

    int vecs = 0, errs = 0, cyc = 0, tStart = 0;
    int nStart, nFrtStart, nFrtCyc, nFnh, nVld, nLast, nDone, nErr;
    int firstRdCyc, lastVldCyc, doneCyc, lastDoneCyc;
    int startCyc[8], fnhCyc[8];
    int expAddr;
    logic pVld = 1'b0, pLast = 1'b0;
    bit autoDone = 1'b1, toggleRdy = 1'b0;
    int doneDly = 5;

    peb_frame_sched #(.LENPSUM(LENPSUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_blk(cfg_num_blk),
        .cfg_num_frm(cfg_num_frm), .blk_start(blk_start), .blk_done(blk_done),
        .frt_blk(frt_blk), .fnh_frm(fnh_frm), .pool_rdy(pool_rdy), .pool_en_rd(pool_en_rd),
        .pool_addr_rd(pool_addr_rd), .pool_vld(pool_vld), .pool_last(pool_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // PEC chain model: answers each blk_start with blk_done doneDly cycles later
    initial forever begin
        @(negedge clk);
        if (autoDone && rst_n && blk_start) begin
            repeat (doneDly) @(posedge clk);
            #1 blk_done = 1'b1;
            @(posedge clk);
            #1 blk_done = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 if (toggleRdy) pool_rdy = ~pool_rdy;
    end

    // observer: event counts plus an independent address and read-latency model
    initial forever begin
        @(negedge clk);
        if (blk_start) begin
            if (nStart < 8) startCyc[nStart] = cyc;
            nStart++;
            if (frt_blk) nFrtStart++;
        end
        if (frt_blk) nFrtCyc++;
        if (blk_done) lastDoneCyc = cyc;
        if (fnh_frm) begin
            if (nFnh < 8) fnhCyc[nFnh] = cyc;
            nFnh++;
        end
        if (pool_en_rd) begin
            if (firstRdCyc < 0) firstRdCyc = cyc;
            if (pool_addr_rd !== ADDR_W'(expAddr) || !pool_rdy) nErr++;
            expAddr = (expAddr + 1) % LENPSUM;
        end
        if (rst_n && (pool_vld !== pVld || pool_last !== pLast)) nErr++;
        pVld  = rst_n && pool_en_rd;
        pLast = rst_n && pool_en_rd && pool_addr_rd == ADDR_W'(LENPSUM - 1);
        if (pool_vld) begin
            nVld++;
            lastVldCyc = cyc;
            if (pool_last) nLast++;
        end
        if (done) begin
            nDone++;
            doneCyc = cyc;
        end
    end

    task automatic clearStats();
        nStart = 0; nFrtStart = 0; nFrtCyc = 0; nFnh = 0; nVld = 0; nLast = 0; nDone = 0; nErr = 0;
        firstRdCyc = -1; lastVldCyc = 0; doneCyc = 0; lastDoneCyc = 0; expAddr = 0;
        for (int i = 0; i < 8; i++) begin
            startCyc[i] = 0;
            fnhCyc[i] = 0;
        end
    endtask

    task automatic startLayer(input int nb, input int nf);
        @(posedge clk);
        #1 cfg_num_blk = CNT_W'(nb); cfg_num_frm = CNT_W'(nf); cfg_start = 1'b1; tStart = cyc;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic waitDone(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk);
            ok = nDone > 0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vecs++; if ({blk_start, frt_blk, fnh_frm, pool_en_rd, pool_vld, pool_last, busy, done} !== 8'd0) begin errs++; $display("FAIL reset_outputs got %b exp 00000000", {blk_start, frt_blk, fnh_frm, pool_en_rd, pool_vld, pool_last, busy, done}); end
        vecs++; if (pool_addr_rd !== 4'd0) begin errs++; $display("FAIL reset_addr got %0d exp 0", pool_addr_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if ({blk_start, busy, done, pool_en_rd} !== 4'd0) begin errs++; $display("FAIL idle_outputs got %b exp 0000", {blk_start, busy, done, pool_en_rd}); end
    endtask

    task automatic test_single_frame();
        bit ok;
        clearStats(); doneDly = 5; pool_rdy = 1'b1;
        startLayer(3, 1);
        waitDone(400, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL t1_done_timeout got 0 exp 1"); end
        vecs++; if (startCyc[0] - tStart !== 1) begin errs++; $display("FAIL t1_start_latency got %0d exp 1", startCyc[0] - tStart); end
        vecs++; if (startCyc[1] - startCyc[0] !== 7) begin errs++; $display("FAIL t1_relaunch_gap got %0d exp 7", startCyc[1] - startCyc[0]); end
        vecs++; if (nStart !== 3) begin errs++; $display("FAIL t1_blk_starts got %0d exp 3", nStart); end
        vecs++; if (nFrtStart !== 1) begin errs++; $display("FAIL t1_frt_on_start got %0d exp 1", nFrtStart); end
        vecs++; if (nFrtCyc !== 6) begin errs++; $display("FAIL t1_frt_cycles got %0d exp 6", nFrtCyc); end
        vecs++; if (nFnh !== 1) begin errs++; $display("FAIL t1_fnh_count got %0d exp 1", nFnh); end
        vecs++; if (fnhCyc[0] - lastDoneCyc !== 2) begin errs++; $display("FAIL t1_fnh_latency got %0d exp 2", fnhCyc[0] - lastDoneCyc); end
        vecs++; if (firstRdCyc - fnhCyc[0] !== 1) begin errs++; $display("FAIL t1_drain_start got %0d exp 1", firstRdCyc - fnhCyc[0]); end
        vecs++; if (nVld !== 16) begin errs++; $display("FAIL t1_vld_count got %0d exp 16", nVld); end
        vecs++; if (nLast !== 1) begin errs++; $display("FAIL t1_last_count got %0d exp 1", nLast); end
        vecs++; if (nErr !== 0) begin errs++; $display("FAIL t1_addr_pipe_errs got %0d exp 0", nErr); end
        vecs++; if (nDone !== 1) begin errs++; $display("FAIL t1_done_count got %0d exp 1", nDone); end
        vecs++; if (doneCyc - lastVldCyc !== 1) begin errs++; $display("FAIL t1_done_after_vld got %0d exp 1", doneCyc - lastVldCyc); end
    endtask

    task automatic test_multi_frame();
        bit ok;
        clearStats(); doneDly = 3; toggleRdy = 1'b1;
        startLayer(1, 3);
        waitDone(600, ok);
        toggleRdy = 1'b0;
        @(posedge clk);
        #1 pool_rdy = 1'b1;
        vecs++; if (!ok) begin errs++; $display("FAIL t2_done_timeout got 0 exp 1"); end
        vecs++; if (nStart !== 3) begin errs++; $display("FAIL t2_blk_starts got %0d exp 3", nStart); end
        vecs++; if (nFrtStart !== 3) begin errs++; $display("FAIL t2_frt_on_start got %0d exp 3", nFrtStart); end
        vecs++; if (nFnh !== 3) begin errs++; $display("FAIL t2_fnh_count got %0d exp 3", nFnh); end
        vecs++; if (startCyc[1] - fnhCyc[0] !== 1) begin errs++; $display("FAIL t2_next_frame_start got %0d exp 1", startCyc[1] - fnhCyc[0]); end
        vecs++; if (nVld !== 48) begin errs++; $display("FAIL t2_vld_count got %0d exp 48", nVld); end
        vecs++; if (nLast !== 3) begin errs++; $display("FAIL t2_last_count got %0d exp 3", nLast); end
        vecs++; if (nErr !== 0) begin errs++; $display("FAIL t2_addr_pipe_errs got %0d exp 0", nErr); end
        vecs++; if (nDone !== 1) begin errs++; $display("FAIL t2_done_count got %0d exp 1", nDone); end
    endtask

    task automatic test_drain_stall();
        bit ok;
        int rdyCyc;
        clearStats(); doneDly = 1; pool_rdy = 1'b0;
        startLayer(1, 2);
        repeat (40) @(posedge clk);
        #1;
        vecs++; if (nFnh !== 1) begin errs++; $display("FAIL t3_fnh_withheld got %0d exp 1", nFnh); end
        vecs++; if (nStart !== 2) begin errs++; $display("FAIL t3_starts_during_stall got %0d exp 2", nStart); end
        vecs++; if (nVld !== 0) begin errs++; $display("FAIL t3_no_reads_when_not_rdy got %0d exp 0", nVld); end
        pool_rdy = 1'b1; rdyCyc = cyc;
        waitDone(200, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL t3_done_timeout got 0 exp 1"); end
        vecs++; if (fnhCyc[1] - rdyCyc !== 16) begin errs++; $display("FAIL t3_fnh_after_drain got %0d exp 16", fnhCyc[1] - rdyCyc); end
        vecs++; if (nStart !== 2) begin errs++; $display("FAIL t3_blk_starts got %0d exp 2", nStart); end
        vecs++; if (nVld !== 32) begin errs++; $display("FAIL t3_vld_count got %0d exp 32", nVld); end
        vecs++; if (nErr !== 0) begin errs++; $display("FAIL t3_addr_pipe_errs got %0d exp 0", nErr); end
    endtask

    task automatic test_zero_cfg_and_busy_start();
        bit ok;
        clearStats(); doneDly = 2; pool_rdy = 1'b1;
        startLayer(0, 0);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL t4_busy got %b exp 1", busy); end
        @(posedge clk);
        #1 cfg_num_blk = 8'd4; cfg_num_frm = 8'd4; cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        waitDone(200, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL t4_done_timeout got 0 exp 1"); end
        vecs++; if (nStart !== 1) begin errs++; $display("FAIL t4_blk_starts got %0d exp 1", nStart); end
        vecs++; if (nFnh !== 1) begin errs++; $display("FAIL t4_fnh_count got %0d exp 1", nFnh); end
        vecs++; if (nFrtCyc !== 3) begin errs++; $display("FAIL t4_frt_cycles got %0d exp 3", nFrtCyc); end
        vecs++; if (nVld !== 16) begin errs++; $display("FAIL t4_vld_count got %0d exp 16", nVld); end
        vecs++; if (nDone !== 1) begin errs++; $display("FAIL t4_done_count got %0d exp 1", nDone); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t4_busy_after_done got %b exp 0", busy); end
    endtask

    task automatic test_spurious_done();
        bit ok;
        int d;
        clearStats(); autoDone = 1'b0; pool_rdy = 1'b1;
        startLayer(2, 1);
        blk_done = 1'b1;
        @(posedge clk);
        #1 blk_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vecs++; if (nStart !== 1) begin errs++; $display("FAIL t5_launch_spurious_starts got %0d exp 1", nStart); end
        vecs++; if (frt_blk !== 1'b1) begin errs++; $display("FAIL t5_frt_kept got %b exp 1", frt_blk); end
        blk_done = 1'b1; d = cyc;
        @(posedge clk);
        #1 blk_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 blk_done = 1'b1;
        @(posedge clk);
        #1 blk_done = 1'b0;
        @(posedge clk);
        #1 blk_done = 1'b1;
        @(posedge clk);
        #1 blk_done = 1'b0;
        waitDone(200, ok);
        autoDone = 1'b1;
        vecs++; if (!ok) begin errs++; $display("FAIL t5_done_timeout got 0 exp 1"); end
        vecs++; if (startCyc[1] - d !== 2) begin errs++; $display("FAIL t5_second_start got %0d exp 2", startCyc[1] - d); end
        vecs++; if (fnhCyc[0] - d !== 6) begin errs++; $display("FAIL t5_fnh_cycle got %0d exp 6", fnhCyc[0] - d); end
        vecs++; if (nStart !== 2) begin errs++; $display("FAIL t5_blk_starts got %0d exp 2", nStart); end
        vecs++; if (nFnh !== 1) begin errs++; $display("FAIL t5_fnh_count got %0d exp 1", nFnh); end
        vecs++; if (nVld !== 16) begin errs++; $display("FAIL t5_vld_count got %0d exp 16", nVld); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok, hit;
        clearStats(); doneDly = 1; pool_rdy = 1'b1; hit = 1'b0;
        startLayer(1, 1);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = pool_en_rd && pool_addr_rd == 4'd7;
        end
        rst_n = 1'b0;
        #1;
        vecs++; if (!hit) begin errs++; $display("FAIL t6_reach_addr7 got 0 exp 1"); end
        vecs++; if ({blk_start, frt_blk, fnh_frm, pool_en_rd, pool_vld, pool_last, busy, done} !== 8'd0) begin errs++; $display("FAIL t6_async_outputs got %b exp 00000000", {blk_start, frt_blk, fnh_frm, pool_en_rd, pool_vld, pool_last, busy, done}); end
        vecs++; if (pool_addr_rd !== 4'd0) begin errs++; $display("FAIL t6_async_addr got %0d exp 0", pool_addr_rd); end
        repeat (3) @(negedge clk);
        vecs++; if (nDone !== 0) begin errs++; $display("FAIL t6_no_done got %0d exp 0", nDone); end
        rst_n = 1'b1;
        clearStats();
        startLayer(1, 1);
        waitDone(200, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL t6_restart_timeout got 0 exp 1"); end
        vecs++; if (nVld !== 16) begin errs++; $display("FAIL t6_vld_count got %0d exp 16", nVld); end
        vecs++; if (nErr !== 0) begin errs++; $display("FAIL t6_addr_pipe_errs got %0d exp 0", nErr); end
        vecs++; if (nDone !== 1) begin errs++; $display("FAIL t6_done_count got %0d exp 1", nDone); end
    endtask

    initial begin
        clearStats();
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_drain_stall();
        test_zero_cfg_and_busy_start();
        test_spurious_done();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
